// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_if
// Purpose  : Instruction-in / decoded-immediate-out handshake bundle.
// Revision : 1.0
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      inst_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output in_valid_i, inst_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );

    modport slave (
        input  in_valid_i, inst_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Decode-stage immediate generator behind a 2-entry skid buffer.
// Revision : 1.0
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 32,
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        flush_i,
    imm_gen_pipe_if.slave    bus
);
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_MISC   = 7'b0001111;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_OP32   = 7'b0111011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] c_FMT_I = 3'd0;
    localparam logic [2:0] c_FMT_S = 3'd1;
    localparam logic [2:0] c_FMT_B = 3'd2;
    localparam logic [2:0] c_FMT_U = 3'd3;
    localparam logic [2:0] c_FMT_J = 3'd4;
    localparam logic [2:0] c_FMT_R = 3'd5;

    localparam bit c_RV64 = (XLEN == 64);

    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic            w_is_shift;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_illegal;

    assign w_inst     = bus.inst_i;
    assign w_opcode   = w_inst[6:0];
    assign w_is_shift = (w_inst[14:12] == 3'b001) || (w_inst[14:12] == 3'b101);

    // Every immediate fits in 32 signed bits, so widen once at the end.
    always_comb begin
        w_imm32   = '0;
        w_fmt     = c_FMT_R;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OP_IMM: begin
                w_fmt = c_FMT_I;
                if (SHAMT_ZEXT && w_is_shift)
                    w_imm32 = c_RV64 ? {26'b0, w_inst[25:20]} : {27'b0, w_inst[24:20]};
                else
                    w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            c_OP_IMM32: begin
                if (c_RV64) begin
                    w_fmt = c_FMT_I;
                    if (SHAMT_ZEXT && w_is_shift)
                        w_imm32 = {27'b0, w_inst[24:20]};
                    else
                        w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_LOAD, c_OP_JALR, c_OP_MISC, c_OP_SYSTEM: begin
                w_fmt   = c_FMT_I;
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            c_OP_STORE: begin
                w_fmt   = c_FMT_S;
                w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            c_OP_BRANCH: begin
                w_fmt   = c_FMT_B;
                w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                           w_inst[30:25], w_inst[11:8], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_fmt   = c_FMT_U;
                w_imm32 = {w_inst[31:12], 12'b0};
            end
            c_OP_JAL: begin
                w_fmt   = c_FMT_J;
                w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                           w_inst[20], w_inst[30:21], 1'b0};
            end
            c_OP_OP:   w_fmt = c_FMT_R;
            c_OP_OP32: w_illegal = !c_RV64;
            default:   w_illegal = 1'b1;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    logic [1:0]       r_count;
    logic [XLEN-1:0]  r_imm0,  r_imm1;
    logic [2:0]       r_fmt0,  r_fmt1;
    logic             r_ill0,  r_ill1;
    logic [TAG_W-1:0] r_tag0,  r_tag1;

    logic w_push, w_pop, w_load_head, w_load_tail, w_shift;

    // Handshake terms are masked by flush so a flushed cycle moves nothing.
    assign w_push      = bus.in_valid_i && (r_count != 2'd2) && !flush_i;
    assign w_pop       = (r_count != 2'd0) && bus.out_ready_i && !flush_i;
    assign w_load_head = w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));
    assign w_load_tail = w_push && (r_count == 2'd1) && !w_pop;
    assign w_shift     = w_pop && (r_count == 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= 2'd0;
            r_imm0  <= '0;
            r_fmt0  <= '0;
            r_ill0  <= 1'b0;
            r_tag0  <= '0;
            r_imm1  <= '0;
            r_fmt1  <= '0;
            r_ill1  <= 1'b0;
            r_tag1  <= '0;
        end else begin
            if (flush_i)
                r_count <= 2'd0;
            else
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            if (w_load_head) begin
                r_imm0 <= w_imm;
                r_fmt0 <= w_fmt;
                r_ill0 <= w_illegal;
                r_tag0 <= bus.tag_i;
            end else if (w_shift) begin
                r_imm0 <= r_imm1;
                r_fmt0 <= r_fmt1;
                r_ill0 <= r_ill1;
                r_tag0 <= r_tag1;
            end

            if (w_load_tail) begin
                r_imm1 <= w_imm;
                r_fmt1 <= w_fmt;
                r_ill1 <= w_illegal;
                r_tag1 <= bus.tag_i;
            end
        end
    end

    assign bus.in_ready_o  = (r_count != 2'd2);
    assign bus.out_valid_o = (r_count != 2'd0);
    assign bus.imm_o       = r_imm0;
    assign bus.fmt_o       = r_fmt0;
    assign bus.illegal_o   = r_ill0;
    assign bus.tag_o       = r_tag0;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Directed bench driving three configurations of imm_gen_pipe.
// Revision : 1.0
// ============================================================================
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic [31:0] tag;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // a: XLEN=32 zext shamt, b: XLEN=32 plain I-type, c: XLEN=64 zext shamt
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus_a ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus_b ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus_c ();

    assign bus_a.in_valid_i = in_valid;
    assign bus_a.inst_i     = inst;
    assign bus_a.tag_i      = tag;
    assign bus_a.out_ready_i = out_ready;
    assign bus_b.in_valid_i = in_valid;
    assign bus_b.inst_i     = inst;
    assign bus_b.tag_i      = tag;
    assign bus_b.out_ready_i = out_ready;
    assign bus_c.in_valid_i = in_valid;
    assign bus_c.inst_i     = inst;
    assign bus_c.tag_i      = tag;
    assign bus_c.out_ready_i = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SHAMT_ZEXT(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus_a));
    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SHAMT_ZEXT(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus_b));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SHAMT_ZEXT(1'b1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus_c));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] t);
        in_valid = 1'b1;
        inst     = i;
        tag      = t;
    endtask

    task automatic chk_a(input string name, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic ill, input logic [31:0] t);
        chk({name, "_valid"}, {63'b0, bus_a.out_valid_o}, 64'd1);
        chk({name, "_imm"},   {32'b0, bus_a.imm_o}, {32'b0, imm});
        chk({name, "_fmt"},   {61'b0, bus_a.fmt_o}, {61'b0, fmt});
        chk({name, "_ill"},   {63'b0, bus_a.illegal_o}, {63'b0, ill});
        chk({name, "_tag"},   {32'b0, bus_a.tag_o}, {32'b0, t});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        inst = '0; tag = '0; out_ready = 1'b1;

        // Reset values
        #12;
        chk("rst_valid", {63'b0, bus_a.out_valid_o}, 64'd0);
        chk("rst_imm",   {32'b0, bus_a.imm_o}, 64'd0);
        chk("rst_fmt",   {61'b0, bus_a.fmt_o}, 64'd0);
        chk("rst_ill",   {63'b0, bus_a.illegal_o}, 64'd0);
        chk("rst_tag",   {32'b0, bus_a.tag_o}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", {63'b0, bus_a.in_ready_o}, 64'd1);

        // Back-to-back stream, downstream always ready
        drive(32'hFFF00093, 32'h100); step();
        chk_a("s0", 32'hFFFFFFFF, 3'd0, 1'b0, 32'h100);
        chk("s0_c64", bus_c.imm_o, 64'hFFFFFFFF_FFFFFFFF);
        drive(32'hFE112E23, 32'h104); step();
        chk_a("s1", 32'hFFFFFFFC, 3'd1, 1'b0, 32'h104);
        drive(32'h123452B7, 32'h108); step();
        chk_a("s2", 32'h12345000, 3'd3, 1'b0, 32'h108);
        drive(32'hFF9FF06F, 32'h10C); step();
        chk_a("s3", 32'hFFFFFFF8, 3'd4, 1'b0, 32'h10C);

        // Shift immediate, all three configurations
        drive(32'h4030D093, 32'h110); step();
        chk_a("srai_a", 32'h00000003, 3'd0, 1'b0, 32'h110);
        chk("srai_b", {32'b0, bus_b.imm_o}, 64'h403);
        chk("srai_c", bus_c.imm_o, 64'h3);

        // Illegal opcode 0 still delivered
        drive(32'h00000000, 32'h114); step();
        chk_a("ill0", 32'h0, 3'd5, 1'b1, 32'h114);
        chk("ill0_c", {63'b0, bus_c.illegal_o}, 64'd1);

        // 64-bit-only opcodes: illegal at XLEN=32, legal at XLEN=64
        drive(32'h0000001B, 32'h118); step();
        chk_a("w32", 32'h0, 3'd5, 1'b1, 32'h118);
        chk("w32_c_ill", {63'b0, bus_c.illegal_o}, 64'd0);
        chk("w32_c_fmt", {61'b0, bus_c.fmt_o}, 64'd0);
        drive(32'h0000003B, 32'h11C); step();
        chk("r32_a_ill", {63'b0, bus_a.illegal_o}, 64'd1);
        chk("r32_c_ill", {63'b0, bus_c.illegal_o}, 64'd0);
        chk("r32_c_fmt", {61'b0, bus_c.fmt_o}, 64'd5);

        // R-type and B-type (beq x0,x0,-4)
        drive(32'h002081B3, 32'h120); step();
        chk_a("add", 32'h0, 3'd5, 1'b0, 32'h120);
        drive(32'hFE000EE3, 32'h124); step();
        chk_a("beq", 32'hFFFFFFFC, 3'd2, 1'b0, 32'h124);
        in_valid = 1'b0; step();
        chk("drain_empty", {63'b0, bus_a.out_valid_o}, 64'd0);

        // Backpressure: fill, stall, then release
        out_ready = 1'b0;
        drive(32'h00100093, 32'h1); step();
        chk("bp1_ready", {63'b0, bus_a.in_ready_o}, 64'd1);
        chk_a("bp1", 32'h1, 3'd0, 1'b0, 32'h1);
        drive(32'h00200093, 32'h2); step();
        chk("bp2_ready", {63'b0, bus_a.in_ready_o}, 64'd0);
        chk_a("bp2", 32'h1, 3'd0, 1'b0, 32'h1);
        drive(32'h00300093, 32'h3); step();
        chk("bp3_ready", {63'b0, bus_a.in_ready_o}, 64'd0);
        chk_a("bp_hold1", 32'h1, 3'd0, 1'b0, 32'h1);
        step();
        chk_a("bp_hold2", 32'h1, 3'd0, 1'b0, 32'h1);
        out_ready = 1'b1; step();
        chk_a("bp_out2", 32'h2, 3'd0, 1'b0, 32'h2);
        chk("bp_ready_back", {63'b0, bus_a.in_ready_o}, 64'd1);
        step();
        chk_a("bp_out3", 32'h3, 3'd0, 1'b0, 32'h3);
        in_valid = 1'b0; step();
        chk("bp_nodup", {63'b0, bus_a.out_valid_o}, 64'd0);

        // Flush with full buffer and a same-cycle input
        out_ready = 1'b0;
        drive(32'h00500093, 32'h5); step();
        drive(32'h00600093, 32'h6); step();
        chk("fl_full", {63'b0, bus_a.in_ready_o}, 64'd0);
        drive(32'h00700093, 32'h7);
        flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {63'b0, bus_a.out_valid_o}, 64'd0);
        chk("fl_ready", {63'b0, bus_a.in_ready_o}, 64'd1);
        out_ready = 1'b1; step();
        chk("fl_still_empty", {63'b0, bus_a.out_valid_o}, 64'd0);
        drive(32'h00800093, 32'h8); step();
        chk_a("fl_after", 32'h8, 3'd0, 1'b0, 32'h8);
        in_valid = 1'b0; step();

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(32'h00900093, 32'h9); step();
        drive(32'h00A00093, 32'hA); step();
        in_valid = 1'b0;
        chk_a("ar_pre", 32'h9, 3'd0, 1'b0, 32'h9);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {63'b0, bus_a.out_valid_o}, 64'd0);
        chk("ar_imm",   {32'b0, bus_a.imm_o}, 64'd0);
        chk("ar_tag",   {32'b0, bus_a.tag_o}, 64'd0);
        #1 rst_n = 1'b1;
        #1;
        chk("ar_ready", {63'b0, bus_a.in_ready_o}, 64'd1);
        step();
        chk("ar_empty", {63'b0, bus_a.out_valid_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Accepts instruction words through a valid/ready handshake and classifies each by instruction format.
- Produces the extended immediate, a format code and an illegal-opcode flag, with a sideband tag carried alongside.
- Has a 2-entry skid buffer, so upstream and downstream can stall independently without losing or duplicating instructions.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag (typically the PC), passed through unchanged.
SHAMT_ZEXT, 1, 1 = shift-immediate instructions yield the zero-extended shamt only; 0 = plain I-type extension.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous, active-low reset.
flush_i  input  1  synchronous flush; discards all buffered entries.
in_valid_i  input  1  upstream has an instruction.
in_ready_o  output  1  block can accept an instruction this cycle.
inst_i  input  32  instruction word.
tag_i  input  TAG_W  sideband tag.
out_valid_o  output  1  head entry is valid.
out_ready_i  input  1  downstream accepts the head entry.
imm_o  output  XLEN  extended immediate of the head entry.
fmt_o  output  3  format code: I=0, S=1, B=2, U=3, J=4, R=5.
illegal_o  output  1  head entry has an unrecognised opcode.
tag_o  output  TAG_W  tag of the head entry.

Behaviour:
- Reset (rst_ni low, asynchronous): occupancy count=0, out_valid_o=0, imm_o=0, fmt_o=0, illegal_o=0, tag_o=0. in_ready_o is 1 as soon as reset deasserts.
- Handshakes:
  - An input transfer occurs when in_valid_i & in_ready_o.
  - An output transfer occurs when out_valid_o & out_ready_i.
  - in_ready_o = (count != 2). It depends on registered state only, with no combinational path from out_ready_i.
- Latency: an instruction accepted in cycle N is visible on the outputs in cycle N+1 when the buffer was empty. Throughput is 1 instruction/cycle when downstream is always ready.
- Decode is combinational on inst_i; the results (imm, fmt, illegal, tag) are registered into the buffer on acceptance.
- Buffer: 2-entry FIFO, head entry drives the outputs. Order is preserved.
  - count 0: accept only.
  - count 1: simultaneous accept and drain keeps count=1, and the head is replaced by the new entry.
  - count 2: no accept; drain moves the second entry to the head.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Opcode map (inst[6:0]):
  - I-type: 0010011, 0000011, 1100111, 0001111, 1110011, 0011011 (XLEN=64 only). Immediate = sext(inst[31:20]).
  - Shift immediates (opcode 0010011 or 0011011, funct3 001/101) with SHAMT_ZEXT=1: immediate = zext(inst[24:20]) when XLEN=32 or opcode 0011011; zext(inst[25:20]) when XLEN=64 and opcode 0010011.
  - S-type (0100011): sext({inst[31:25], inst[11:7]}).
  - B-type (1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U-type (0110111, 0010111): sext({inst[31:12], 12'b0}) to XLEN.
  - J-type (1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R-type: 0110011, plus 0111011 when XLEN=64. Immediate=0, fmt=R.
  - Any other opcode, including 0011011/0111011 when XLEN=32: illegal=1, imm=0, fmt=R. The entry is still buffered and delivered, not dropped.
- Sign extension always uses inst[31] to fill up to XLEN.
- Flush:
  - flush_i=1 sets count=0 next cycle and clears out_valid_o.
  - Any input presented in the same cycle is not accepted (in_ready_o still reads its registered value, but the transfer is discarded).
  - Flush takes priority over both accept and drain.
- Reset mid-stream: all entries are lost immediately and outputs return to their reset values asynchronously.

Test Plan:
- XLEN=32, out_ready_i=1. Stream 0xFFF00093 (addi -1), 0xFE112E23 (sw -4), 0x123452B7 (lui), 0xFF9FF06F (jal -8) back-to-back -> one cycle after each input: imm_o = 0xFFFFFFFF/I, 0xFFFFFFFC/S, 0x12345000/U, 0xFFFFFFF8/J, in order, with tags matching.
- Shift immediate: 0x4030D093 (srai x1,x1,3) with SHAMT_ZEXT=1 -> imm_o=0x00000003, fmt=I. Same input with SHAMT_ZEXT=0 -> imm_o=0x00000403.
- Backpressure: out_ready_i=0, push 3 instructions -> in_ready_o drops to 0 after 2 are accepted. Raise out_ready_i -> all 3 delivered in order, none duplicated, outputs stable while stalled.
- Illegal and XLEN=64: XLEN=64, 0xFFF00093 -> imm_o=0xFFFFFFFFFFFFFFFF. Opcode 0000000 -> illegal_o=1, imm_o=0, still delivered. XLEN=32, 0x0000001B -> illegal_o=1.
- Flush: buffer full, assert flush_i together with in_valid_i -> next cycle out_valid_o=0, count=0, flushed and same-cycle inputs never appear on the outputs.
- Async reset: assert rst_ni low between clock edges with 2 entries buffered -> out_valid_o=0, imm_o=0, tag_o=0 immediately; after release, in_ready_o=1.
